// File: rtl/dp_mem_bist_pkg.sv
// Shared constants for the dual-port memory BIST: pattern modes and FSM state encodings.
package dp_mem_bist_pkg;

    localparam logic [1:0] MODE_CONST = 2'd0;
    localparam logic [1:0] MODE_ADDR  = 2'd1;
    localparam logic [1:0] MODE_CHECK = 2'd2;
    localparam logic [1:0] MODE_INV   = 2'd3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WRITE = 3'd1;
    localparam logic [2:0] ST_READ  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/dp_mem_bist_if.sv
// Both ports of a true dual-port synchronous RAM; the BIST is the master, the RAM the slave.
interface dp_mem_bist_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] addr1;
    logic              we1;
    logic [DATA_W-1:0] dataIn1;
    logic [DATA_W-1:0] dataOut1;
    logic [ADDR_W-1:0] addr2;
    logic              we2;
    logic [DATA_W-1:0] dataIn2;
    logic [DATA_W-1:0] dataOut2;

    modport master (
        output addr1, we1, dataIn1, addr2, we2, dataIn2,
        input  dataOut1, dataOut2
    );

    modport slave (
        input  addr1, we1, dataIn1, addr2, we2, dataIn2,
        output dataOut1, dataOut2
    );
endinterface

// File: rtl/dp_mem_bist_pattern.sv
// Combinational test-pattern generator: pat(a) for the selected mode and seed.
module dp_mem_bist_pattern
    import dp_mem_bist_pkg::*;
#(
    parameter int          DATA_W = 16,
    parameter int          ADDR_W = 8,
    parameter int unsigned SEED   = 16'h0045
) (
    input  logic [ADDR_W-1:0] a,
    input  logic [1:0]        mode,
    output logic [DATA_W-1:0] pat
);
    localparam logic [DATA_W-1:0] SEED_W = DATA_W'(SEED);
    localparam logic [DATA_W-1:0] CHECK  = {(DATA_W/2){2'b01}};

    logic [DATA_W-1:0] a_ext;

    always_comb begin
        a_ext = DATA_W'(a);
        pat   = SEED_W;
        case (mode)
            MODE_CONST: pat = SEED_W;
            MODE_ADDR:  pat = a_ext ^ SEED_W;
            MODE_CHECK: pat = a[0] ? ~CHECK : CHECK;
            MODE_INV:   pat = ~a_ext;
            default:    pat = SEED_W;
        endcase
    end
endmodule

// File: rtl/dp_mem_bist.sv
// Dual-port RAM BIST: pattern write over a window, read-back compare, error reporting.
// Optional STOP_ON_FAIL_EN: end the test at the first mismatching compare.
module dp_mem_bist
    import dp_mem_bist_pkg::*;
#(
    parameter int          DATA_W     = 16,
    parameter int          ADDR_W     = 8,
    parameter int          START_ADDR = 0,
    parameter int          END_ADDR   = 255,
    parameter int unsigned SEED       = 16'h0045
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    dp_mem_bist_if.master     mem,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_fail_addr
);
    localparam int NPAIRS = (END_ADDR - START_ADDR + 1) / 2;
    localparam logic [ADDR_W-1:0] START_A   = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] LAST_PAIR = ADDR_W'(NPAIRS - 1);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

    logic [2:0]        state;
    logic [ADDR_W-1:0] idx;
    logic [1:0]        mode_q;
    logic [ADDR_W-1:0] a1_q, a2_q;
    logic              we_q;
    logic [DATA_W-1:0] d1_q, d2_q;
    logic              cmp_vld;
    logic [ADDR_W-1:0] cmp_a1, cmp_a2;

    logic [ADDR_W-1:0] nxt_pair, wr_a1, wr_a2, pa_in, pb_in;
    logic [1:0]        pat_mode;
    logic [DATA_W-1:0] pat_a, pat_b;
    logic              last_pair, cmp_phase, mis1, mis2;
    logic [ADDR_W+1:0] err_sum;
    logic [ADDR_W:0]   err_nxt;

    // The two generators serve write data while writing and expected data while comparing.
    always_comb begin
        last_pair = (idx == LAST_PAIR);
        nxt_pair  = (state == ST_IDLE) ? '0 : idx + ONE;
        wr_a1     = START_A + (nxt_pair << 1);
        wr_a2     = wr_a1 + ONE;
        cmp_phase = (state == ST_READ) || (state == ST_DRAIN);
        pa_in     = cmp_phase ? cmp_a1 : wr_a1;
        pb_in     = cmp_phase ? cmp_a2 : wr_a2;
        pat_mode  = (state == ST_IDLE) ? mode : mode_q;
    end

    dp_mem_bist_pattern #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SEED(SEED)) u_pat_a (
        .a(pa_in), .mode(pat_mode), .pat(pat_a)
    );
    dp_mem_bist_pattern #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SEED(SEED)) u_pat_b (
        .a(pb_in), .mode(pat_mode), .pat(pat_b)
    );

    always_comb begin
        mis1    = cmp_vld && (mem.dataOut1 != pat_a);
        mis2    = cmp_vld && (mem.dataOut2 != pat_b);
        err_sum = {1'b0, err_count} + (ADDR_W+2)'({1'b0, mis1}) + (ADDR_W+2)'({1'b0, mis2});
        err_nxt = err_sum[ADDR_W+1] ? '1 : err_sum[ADDR_W:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= ST_IDLE;
            idx             <= '0;
            mode_q          <= '0;
            a1_q            <= '0;
            a2_q            <= '0;
            we_q            <= 1'b0;
            d1_q            <= '0;
            d2_q            <= '0;
            cmp_vld         <= 1'b0;
            cmp_a1          <= '0;
            cmp_a2          <= '0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_fail_addr <= '0;
        end else begin
            cmp_vld <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    mode_q          <= mode;
                    err_count       <= '0;
                    first_fail_addr <= '0;
                    pass            <= 1'b0;
                    idx             <= '0;
                    a1_q            <= wr_a1;
                    a2_q            <= wr_a2;
                    d1_q            <= pat_a;
                    d2_q            <= pat_b;
                    we_q            <= 1'b1;
                    state           <= ST_WRITE;
                end
                ST_WRITE: if (last_pair) begin
                    idx   <= '0;
                    we_q  <= 1'b0;
                    a1_q  <= START_A;
                    a2_q  <= START_A + ONE;
                    state <= ST_READ;
                end else begin
                    idx  <= nxt_pair;
                    a1_q <= wr_a1;
                    a2_q <= wr_a2;
                    d1_q <= pat_a;
                    d2_q <= pat_b;
                end
                ST_READ: begin
                    cmp_vld <= 1'b1;
                    cmp_a1  <= a1_q;
                    cmp_a2  <= a2_q;
                    if (last_pair) begin
                        state <= ST_DRAIN;
                    end else begin
                        idx  <= nxt_pair;
                        a1_q <= wr_a1;
                        a2_q <= wr_a2;
                    end
                end
                ST_DRAIN: begin
                    pass  <= (err_nxt == '0);
                    state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase

            if (cmp_vld) begin
                err_count <= err_nxt;
                if ((err_count == '0) && (mis1 || mis2))
                    first_fail_addr <= mis1 ? cmp_a1 : cmp_a2;
            end
`ifdef STOP_ON_FAIL_EN
            if (mis1 || mis2) begin
                state   <= ST_DONE;
                cmp_vld <= 1'b0;
                pass    <= 1'b0;
            end
`endif
        end
    end

    assign mem.addr1   = a1_q;
    assign mem.addr2   = a2_q;
    assign mem.we1     = we_q;
    assign mem.we2     = we_q;
    assign mem.dataIn1 = d1_q;
    assign mem.dataIn2 = d2_q;
    assign busy = (state == ST_WRITE) || (state == ST_READ) || (state == ST_DRAIN);
    assign done = (state == ST_DONE);
endmodule

// File: tb/tb_dp_mem_bist.sv
// Randomized bench for dp_mem_bist: behavioural RAM with read faults plus a cycle-level reference model.
module tb_dp_mem_bist;
    localparam int NP = 4;
    localparam int S  = 0;
    localparam int E  = 7;
    localparam int SEEDV = 69;
`ifdef STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, start;
    logic [1:0]  mode;
    logic        busy, done, pass;
    logic [8:0]  err_count;
    logic [7:0]  first_fail_addr;

    dp_mem_bist_if #(.DATA_W(16), .ADDR_W(8)) mif ();

    dp_mem_bist #(.DATA_W(16), .ADDR_W(8), .START_ADDR(S), .END_ADDR(E), .SEED(SEEDV)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .mem(mif.master),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_fail_addr(first_fail_addr)
    );

    always #5 clk = ~clk;

    // RAM with per-address forced read values
    logic [15:0] ram [0:255];
    bit          fault_en [0:255];
    logic [15:0] fault_val [0:255];

    always @(posedge clk) begin
        if (mif.we1) ram[mif.addr1] <= mif.dataIn1;
        if (mif.we2) ram[mif.addr2] <= mif.dataIn2;
        mif.dataOut1 <= fault_en[mif.addr1] ? fault_val[mif.addr1] : ram[mif.addr1];
        mif.dataOut2 <= fault_en[mif.addr2] ? fault_val[mif.addr2] : ram[mif.addr2];
    end

    function automatic logic [15:0] pat(input int a, input int m);
        case (m)
            0:       return 16'(SEEDV);
            1:       return 16'(a ^ SEEDV);
            2:       return (a % 2 == 0) ? 16'h5555 : 16'hAAAA;
            default: return 16'(65535 - a);
        endcase
    endfunction

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Stimulus-owned expectations for directed runs
    bit chk_en = 1'b0;
    bit pin_valid = 1'b0;
    int pin_done, pin_err, pin_ffa;
    bit pin_pass;

    // Reference model state
    bit   active = 1'b0, pend_zero = 1'b0, pinned = 1'b0;
    int   cyc, exp_done, last_err = 0, last_ffa = 0;
    bit   last_pass = 1'b0;
    int   n_dut_done = 0, n_mod_done = 0;
    int   m_mode;
    bit   m_mis [0:255];

    always @(negedge clk) begin
        int ve, vf, p0, c;
        bit vfound;
        if (chk_en) begin
            if (!pinned) begin
                pinned = 1'b1;
                chk("pin_pat_m0", 32'(pat(7, 0)), 32'h0045);
                chk("pin_pat_m1_a3", 32'(pat(3, 1)), 32'h0046);
                chk("pin_pat_m2_even", 32'(pat(0, 2)), 32'h5555);
                chk("pin_pat_m2_odd", 32'(pat(1, 2)), 32'hAAAA);
                chk("pin_pat_m3", 32'(pat(5, 3)), 32'hFFFA);
            end
            if (done === 1'b1) n_dut_done++;
            if (pend_zero) begin
                chk("rst_addr1", 32'(mif.addr1), 0);
                chk("rst_addr2", 32'(mif.addr2), 0);
                chk("rst_dataIn1", 32'(mif.dataIn1), 0);
                chk("rst_dataIn2", 32'(mif.dataIn2), 0);
            end
            pend_zero = 1'b0;
            if (active) begin
                cyc++;
                ve = 0; vf = 0; vfound = 1'b0;
                for (int p = 0; p < NP; p++)
                    if (NP + 2 + p < cyc)
                        for (int j = 0; j < 2; j++)
                            if (m_mis[S+2*p+j]) begin
                                ve++;
                                if (!vfound) begin vfound = 1'b1; vf = S + 2*p + j; end
                            end
                chk("busy", 32'(busy), 32'(cyc < exp_done));
                chk("done", 32'(done), 32'(cyc == exp_done));
                chk("err_count", 32'(err_count), ve);
                chk("first_fail_addr", 32'(first_fail_addr), vf);
                if (cyc <= NP) begin
                    chk("we1_write", 32'(mif.we1), 1);
                    chk("we2_write", 32'(mif.we2), 1);
                    chk("addr1_write", 32'(mif.addr1), S + 2*(cyc-1));
                    chk("addr2_write", 32'(mif.addr2), S + 2*(cyc-1) + 1);
                    chk("dataIn1_write", 32'(mif.dataIn1), 32'(pat(S + 2*(cyc-1), m_mode)));
                    chk("dataIn2_write", 32'(mif.dataIn2), 32'(pat(S + 2*(cyc-1) + 1, m_mode)));
                end else begin
                    chk("we1_idle", 32'(mif.we1), 0);
                    chk("we2_idle", 32'(mif.we2), 0);
                    chk("dataIn1_hold", 32'(mif.dataIn1), 32'(pat(S + 2*(NP-1), m_mode)));
                    chk("dataIn2_hold", 32'(mif.dataIn2), 32'(pat(S + 2*(NP-1) + 1, m_mode)));
                    if (cyc < exp_done && cyc <= 2*NP) begin
                        chk("addr1_read", 32'(mif.addr1), S + 2*(cyc-NP-1));
                        chk("addr2_read", 32'(mif.addr2), S + 2*(cyc-NP-1) + 1);
                    end
                end
                if (cyc == exp_done) begin
                    chk("pass_done", 32'(pass), 32'(ve == 0));
                    n_mod_done++;
                    chk("done_pulse_count", n_dut_done, n_mod_done);
                    if (pin_valid) begin
                        chk("pin_done_cycle", cyc, pin_done);
                        chk("pin_err", 32'(err_count), pin_err);
                        chk("pin_ffa", 32'(first_fail_addr), pin_ffa);
                        chk("pin_pass", 32'(pass), 32'(pin_pass));
                    end
                    last_err = ve; last_ffa = vf; last_pass = (ve == 0);
                    active = 1'b0;
                end
            end else begin
                chk("idle_we1", 32'(mif.we1), 0);
                chk("idle_we2", 32'(mif.we2), 0);
                chk("idle_busy", 32'(busy), 0);
                chk("idle_done", 32'(done), 0);
                chk("idle_pass", 32'(pass), 32'(last_pass));
                chk("idle_err", 32'(err_count), last_err);
                chk("idle_ffa", 32'(first_fail_addr), last_ffa);
                if (start === 1'b1 && reset === 1'b1) begin
                    active = 1'b1; cyc = 0; m_mode = int'(mode); p0 = -1;
                    for (int a = S; a <= E; a++)
                        m_mis[a] = fault_en[a] && (fault_val[a] != pat(a, m_mode));
                    for (int p = 0; p < NP; p++) begin
                        c = int'(m_mis[S+2*p]) + int'(m_mis[S+2*p+1]);
                        if (c != 0 && p0 < 0) p0 = p;
                    end
                    exp_done = (STOP && p0 >= 0) ? NP + 3 + p0 : 2*NP + 2;
                end
            end
            if (reset === 1'b0) begin
                active = 1'b0; pend_zero = 1'b1;
                last_err = 0; last_ffa = 0; last_pass = 1'b0;
            end
        end
    end

    task automatic clear_faults();
        for (int a = 0; a < 256; a++) begin fault_en[a] = 1'b0; fault_val[a] = '0; end
    endtask

    task automatic set_pin(input int d, input int e, input int f, input bit p);
        pin_valid = 1'b1; pin_done = d; pin_err = e; pin_ffa = f; pin_pass = p;
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance
    task automatic launch(input logic [1:0] m);
        start = 1'b1; mode = m;
        @(posedge clk); #1;
        start = 1'b0; mode = 2'($urandom);
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int nf, a, rst_at, st_at;
        reset = 1'b0; start = 1'b0; mode = '0;
        clear_faults();
        settle(3);
        chk_en = 1'b1;
        settle(1);
        reset = 1'b1;
        settle(2);

        set_pin(10, 0, 0, 1'b1);
        launch(2'd0); settle(2*NP + 4);

        set_pin(10, 0, 0, 1'b1);
        launch(2'd1); settle(2*NP + 4);

        fault_en[3] = 1'b1; fault_val[3] = 16'd21;
        set_pin(STOP ? 8 : 10, 1, 3, 1'b0);
        launch(2'd2); settle(2*NP + 4);

        clear_faults();
        fault_en[2] = 1'b1; fault_val[2] = 16'h0000;
        fault_en[3] = 1'b1; fault_val[3] = 16'h0000;
        set_pin(STOP ? 8 : 10, 2, 2, 1'b0);
        launch(2'd0); settle(2*NP + 4);
        clear_faults();

        set_pin(10, 0, 0, 1'b1);
        launch(2'd1);
        settle(NP + 1);
        start = 1'b1;
        settle(1);
        start = 1'b0;
        settle(NP + 3);

        pin_valid = 1'b0;
        launch(2'd0);
        settle(2);
        reset = 1'b0;
        settle(1);
        reset = 1'b1;
        settle(4);
        set_pin(10, 0, 0, 1'b1);
        launch(2'd3); settle(2*NP + 4);
        pin_valid = 1'b0;

        for (int r = 0; r < 40; r++) begin
            clear_faults();
            nf = $urandom_range(0, 3);
            for (int f = 0; f < nf; f++) begin
                a = $urandom_range(S, E);
                fault_en[a] = 1'b1;
                fault_val[a] = 16'($urandom);
            end
            rst_at = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2*NP) : 0;
            st_at  = (rst_at == 0 && $urandom_range(0, 1) == 1) ? $urandom_range(2, NP) : 0;
            launch(2'($urandom));
            for (int k = 1; k <= 2*NP + 4; k++) begin
                reset = (k == rst_at) ? 1'b0 : 1'b1;
                start = (k == st_at);
                mode  = 2'($urandom);
                settle(1);
            end
            reset = 1'b1; start = 1'b0;
        end

        settle(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
